result_bcd_converter: RTL and testbench



---
 rtl/result_bcd_converter.sv | 196 +++++++++++++++++++
 tb/tb_result_bcd_converter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/result_bcd_converter.sv
// result_bcd_converter
// Captures the adder result and flags on a start strobe, then converts the
// 9-bit magnitude to three BCD digits with an iterative double-dabble
// sequencer (one shift per clock, nine shifts). The digits and flags are
// registered and hold until the next conversion completes.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   conversion request, only sampled while idle
//   sgn      in   1 = signed (subtract mode), 0 = unsigned
//   S        in   8-bit adder sum
//   Cout     in   adder carry-out (ninth bit in unsigned mode)
//   OVR      in   adder signed overflow flag
//   ZERO     in   adder zero flag
//   NEG      in   adder sign flag
//   busy     out  conversion in progress
//   valid    out  one-cycle pulse when new digits appear
//   hundreds out  BCD hundreds digit
//   tens     out  BCD tens digit
//   ones     out  BCD ones digit
//   minus    out  display minus sign
//   err      out  signed overflow, result not representable
//   zero     out  captured ZERO flag
module result_bcd_converter (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sgn,
  input  logic [7:0] S,
  input  logic       Cout,
  input  logic       OVR,
  input  logic       ZERO,
  input  logic       NEG,
  output logic       busy,
  output logic       valid,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       minus,
  output logic       err,
  output logic       zero
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  b9_q, b9_d;
  logic [11:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        mnus_q, mnus_d;
  logic        ovf_q, ovf_d;
  logic        zf_q, zf_d;
  logic        valid_q, valid_d;
  logic [3:0]  hund_q, hund_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;
  logic        minus_q, minus_d;
  logic        err_q, err_d;
  logic        zero_q, zero_d;

  logic [11:0] bcd_adj_s;
  logic [20:0] shift_s;
  logic [7:0]  mag_s;

  // Double-dabble correction: a nibble of 5 or more would overflow past 9
  // after the shift, so pre-add 3.
  function automatic logic [3:0] add3(input logic [3:0] n);
    if (n >= 4'd5) begin
      add3 = n + 4'd3;
    end else begin
      add3 = n;
    end
  endfunction

  // Correction of all three nibbles, then shift of the combined register.
  always_comb begin
    bcd_adj_s = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    shift_s   = {bcd_adj_s, b9_q} << 1;
  end

  // Magnitude of the captured sum: two's-complement negate when NEG in signed mode.
  always_comb begin
    if (NEG) begin
      mag_s = ~S + 8'd1;
    end else begin
      mag_s = S;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    b9_d    = b9_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    mnus_d  = mnus_q;
    ovf_d   = ovf_q;
    zf_d    = zf_q;
    valid_d = 1'b0;
    hund_d  = hund_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    minus_d = minus_q;
    err_d   = err_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (sgn) begin
            b9_d = {1'b0, mag_s};
          end else begin
            b9_d = {Cout, S};
          end
          mnus_d  = sgn & NEG;
          ovf_d   = sgn & OVR;
          zf_d    = ZERO;
          bcd_d   = 12'd0;
          cnt_d   = 4'd0;
          state_d = CONV;
        end else begin
          state_d = IDLE;
        end
      end
      CONV: begin
        bcd_d = shift_s[20:9];
        b9_d  = shift_s[8:0];
        cnt_d = cnt_q + 4'd1;
        // Ninth shift completes on this edge; publish the shifted value directly.
        if (cnt_q == 4'd8) begin
          hund_d  = shift_s[20:17];
          tens_d  = shift_s[16:13];
          ones_d  = shift_s[12:9];
          minus_d = mnus_q;
          err_d   = ovf_q;
          zero_d  = zf_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = CONV;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      b9_q    <= 9'd0;
      bcd_q   <= 12'd0;
      cnt_q   <= 4'd0;
      mnus_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zf_q    <= 1'b0;
      valid_q <= 1'b0;
      hund_q  <= 4'd0;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      minus_q <= 1'b0;
      err_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      b9_q    <= b9_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      mnus_q  <= mnus_d;
      ovf_q   <= ovf_d;
      zf_q    <= zf_d;
      valid_q <= valid_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      minus_q <= minus_d;
      err_q   <= err_d;
      zero_q  <= zero_d;
    end
  end

  assign busy     = (state_q == CONV);
  assign valid    = valid_q;
  assign hundreds = hund_q;
  assign tens     = tens_q;
  assign ones     = ones_q;
  assign minus    = minus_q;
  assign err      = err_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_result_bcd_converter.sv
module tb_result_bcd_converter;

  logic       clk;
  logic       rst;
  logic       start;
  logic       sgn;
  logic [7:0] S;
  logic       Cout;
  logic       OVR;
  logic       ZERO;
  logic       NEG;
  logic       busy;
  logic       valid;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       minus;
  logic       err;
  logic       zero;

  typedef struct packed {
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] o;
    logic       m;
    logic       e;
    logic       z;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int   n_tests = 0;
  int   n_fail  = 0;

  result_bcd_converter dut (
    .clk(clk), .rst(rst), .start(start), .sgn(sgn), .S(S), .Cout(Cout),
    .OVR(OVR), .ZERO(ZERO), .NEG(NEG), .busy(busy), .valid(valid),
    .hundreds(hundreds), .tens(tens), .ones(ones), .minus(minus),
    .err(err), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic sg, input logic [7:0] s, input logic c,
                                 input logic ovr, input logic zr, input logic ng);
    exp_t r;
    int   mag;
    if (sg) begin
      if (ng) mag = (256 - int'(s)) % 256;
      else    mag = int'(s);
    end else begin
      mag = int'(c) * 256 + int'(s);
    end
    r.h = 4'(mag / 100);
    r.t = 4'((mag / 10) % 10);
    r.o = 4'(mag % 10);
    r.m = sg & ng;
    r.e = sg & ovr;
    r.z = zr;
    return r;
  endfunction

  // Scoreboard: every valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: got valid=1 with no conversion pending, required none");
      end else begin
        exp_t e;
        e = sb.pop_front();
        last_exp = e;
        if ({hundreds, tens, ones, minus, err, zero} !== {e.h, e.t, e.o, e.m, e.e, e.z}) begin
          n_fail++;
          $display("FAIL result: got %0d%0d%0d m=%0b e=%0b z=%0b, required %0d%0d%0d m=%0b e=%0b z=%0b",
                   hundreds, tens, ones, minus, err, zero, e.h, e.t, e.o, e.m, e.e, e.z);
        end
      end
    end
  end

  // Drive one conversion; returns in the cycle where valid must be high.
  // inject != 0 changes S and pulses start in busy cycle 4 (must be ignored).
  task automatic run_conv(input logic sg, input logic [7:0] s, input logic c,
                          input logic ovr, input logic zr, input logic ng, input int inject);
    sgn = sg; S = s; Cout = c; OVR = ovr; ZERO = zr; NEG = ng;
    start = 1'b1;
    sb.push_back(model(sg, s, c, ovr, zr, ng));
    @(posedge clk); #1;
    start = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_cycle1: got busy=%b valid=%b, required busy=1 valid=0", busy, valid);
    end
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (inject != 0 && i == 3) begin
        S = ~s; NEG = ~ng; Cout = ~c; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      n_tests++;
      if (busy !== 1'b1 || valid !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_cycle%0d: got busy=%b valid=%b, required busy=1 valid=0", i + 1, busy, valid);
      end
    end
    @(posedge clk); #1;
    n_tests++;
    if (valid !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL latency: got valid=%b busy=%b after 9 edges, required valid=1 busy=0", valid, busy);
    end
  endtask

  task automatic idle_check_pulse;
    @(posedge clk); #1;
    n_tests++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_width: got valid=%b in cycle after pulse, required 0", valid);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; sgn = 1'b0; S = 8'h00; Cout = 1'b0;
    OVR = 1'b0; ZERO = 1'b0; NEG = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_tests++;
    if ({busy, valid, hundreds, tens, ones, minus, err, zero} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required all zero",
               {busy, valid, hundreds, tens, ones, minus, err, zero});
    end
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle: got valid=%b busy=%b, required 0 0", valid, busy);
      end
    end
  endtask

  task automatic test_unsigned;
    run_conv(1'b0, 8'h2C, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    idle_check_pulse();
    run_conv(1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1, 0);  // 510, NEG ignored
    idle_check_pulse();
  endtask

  task automatic test_signed_neg;
    run_conv(1'b1, 8'hFB, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    idle_check_pulse();
    run_conv(1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    idle_check_pulse();
    run_conv(1'b1, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    idle_check_pulse();
  endtask

  task automatic test_ovf_zero;
    run_conv(1'b1, 8'h82, 1'b0, 1'b1, 1'b0, 1'b1, 0);
    idle_check_pulse();
    run_conv(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    idle_check_pulse();
  endtask

  task automatic test_back_to_back;
    run_conv(1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    run_conv(1'b0, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 0);   // starts in the valid cycle
    idle_check_pulse();
    // Outputs must hold between conversions.
    repeat (5) @(posedge clk);
    #1;
    n_tests++;
    if ({hundreds, tens, ones, minus, err, zero} !==
        {last_exp.h, last_exp.t, last_exp.o, last_exp.m, last_exp.e, last_exp.z}) begin
      n_fail++;
      $display("FAIL hold: got %0d%0d%0d, required %0d%0d%0d",
               hundreds, tens, ones, last_exp.h, last_exp.t, last_exp.o);
    end
  endtask

  task automatic test_reset_mid;
    logic seen;
    sgn = 1'b0; S = 8'hC8; Cout = 1'b0; OVR = 1'b0; ZERO = 1'b0; NEG = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b1;    // reset wins over a simultaneous start
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    n_tests++;
    if ({busy, valid, hundreds, tens, ones, minus, err, zero} !== 17'd0) begin
      n_fail++;
      $display("FAIL abort_outputs: got %b, required all zero",
               {busy, valid, hundreds, tens, ones, minus, err, zero});
    end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: got activity after reset, required none");
    end
    run_conv(1'b0, 8'h2A, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    idle_check_pulse();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed_neg();
    test_ovf_zero();
    test_back_to_back();
    test_reset_mid();
    @(posedge clk); #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
